// File: rtl/axis_pkt_checker.sv
// AXI-Stream sink that checks framing, tkeep and per-flow sequence order, keeps running
// counters and a periodic throughput snapshot. Define PKT_CHECK_BP_EN for LFSR backpressure.
module axis_pkt_checker #(
    parameter int DATA_WIDTH   = 512,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int MIN_BEATS    = 1,
    parameter int MAX_BEATS    = 32,
    parameter int FLOW_IDX_W   = 4,
    parameter int LOG_INTERVAL = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [31:0]           pkt_count,
    output logic [47:0]           byte_count,
    output logic [15:0]           err_keep_count,
    output logic [15:0]           err_len_count,
    output logic [15:0]           err_seq_count,
    output logic                  error_flag,
    output logic                  log_valid,
    output logic [31:0]           log_pkts,
    output logic [47:0]           log_bytes
);
    localparam int FLOWS = 1 << FLOW_IDX_W;
    localparam int BCW   = $clog2(MAX_BEATS + 2);
    localparam int CYCW  = (LOG_INTERVAL > 1) ? $clog2(LOG_INTERVAL) : 1;
    localparam int PCW   = $clog2(KEEP_WIDTH + 1);

    typedef enum logic [1:0] {S_HEAD, S_BODY, S_SKIP} state_t;

    state_t                state, state_next;
    logic [BCW-1:0]        beat_cnt, beat_cnt_next, beats_now;
    logic [8:0]            seq_q, cur_seq, seq_diff;
    logic [7:0]            flow_q, cur_flow;
    logic [FLOW_IDX_W-1:0] idx;
    logic [FLOWS-1:0]      tbl_valid;
    logic [8:0]            tbl_seq [FLOWS];
    logic [KEEP_WIDTH-1:0] keep_inc;
    logic [PCW-1:0]        beat_bytes;
    logic                  accept, keep_bad, keep_err, len_err, seq_chk, seq_err, pkt_done;
    logic [CYCW-1:0]       cyc;
    logic [31:0]           int_pkts, pkts_sum;
    logic [47:0]           int_bytes, bytes_sum;

`ifdef PKT_CHECK_BP_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign s_axis_tready = !rst && (lfsr[1:0] != 2'b00);
`else
    assign s_axis_tready = 1'b1;
`endif

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) beat_bytes = beat_bytes + PCW'(s_axis_tkeep[i]);
    end

    // Head beats use live tdata; later beats use the seq/flow captured from the head.
    always_comb begin
        accept     = s_axis_tvalid && s_axis_tready;
        beats_now  = (state == S_HEAD) ? BCW'(1) : beat_cnt + BCW'(1);
        cur_seq    = (state == S_HEAD) ? s_axis_tdata[8:0] : seq_q;
        cur_flow   = (state == S_HEAD) ? s_axis_tdata[35*8 +: 8] : flow_q;
        idx        = cur_flow[FLOW_IDX_W-1:0];
        seq_diff   = cur_seq - tbl_seq[idx];
        keep_inc   = s_axis_tkeep + KEEP_WIDTH'(1);
        keep_bad   = s_axis_tlast ? ((s_axis_tkeep == '0) || ((s_axis_tkeep & keep_inc) != '0))
                                  : (s_axis_tkeep != '1);
        state_next    = state;
        beat_cnt_next = beat_cnt;
        keep_err      = 1'b0;
        len_err       = 1'b0;
        seq_chk       = 1'b0;
        pkt_done      = accept && s_axis_tlast;
        if (accept) begin
            case (state)
                S_HEAD, S_BODY: begin
                    keep_err      = keep_bad;
                    beat_cnt_next = beats_now;
                    if (32'(beats_now) > MAX_BEATS) begin
                        len_err    = 1'b1;
                        state_next = s_axis_tlast ? S_HEAD : S_SKIP;
                    end else if (s_axis_tlast) begin
                        len_err    = 32'(beats_now) < MIN_BEATS;
                        seq_chk    = 1'b1;
                        state_next = S_HEAD;
                    end else begin
                        state_next = S_BODY;
                    end
                end
                S_SKIP:  if (s_axis_tlast) state_next = S_HEAD;
                default: state_next = S_HEAD;
            endcase
        end
        // Serial-number compare: a forward step of 1..255 is legal, so 511 -> 0 passes.
        seq_err   = seq_chk && tbl_valid[idx] && ((seq_diff == '0) || seq_diff[8]);
        pkts_sum  = int_pkts + (pkt_done ? 32'd1 : 32'd0);
        bytes_sum = int_bytes + (accept ? 48'(beat_bytes) : 48'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_HEAD;
            beat_cnt  <= '0;
            seq_q     <= '0;
            flow_q    <= '0;
            tbl_valid <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_cnt_next;
            if (accept && state == S_HEAD) begin
                seq_q  <= s_axis_tdata[8:0];
                flow_q <= s_axis_tdata[35*8 +: 8];
            end
            if (seq_chk) tbl_valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && seq_chk) tbl_seq[idx] <= cur_seq;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count      <= '0;
            byte_count     <= '0;
            err_keep_count <= '0;
            err_len_count  <= '0;
            err_seq_count  <= '0;
            error_flag     <= 1'b0;
        end else begin
            if (pkt_done) pkt_count <= pkt_count + 32'd1;
            if (accept)   byte_count <= byte_count + 48'(beat_bytes);
            if (keep_err && err_keep_count != '1) err_keep_count <= err_keep_count + 16'd1;
            if (len_err && err_len_count != '1)   err_len_count  <= err_len_count + 16'd1;
            if (seq_err && err_seq_count != '1)   err_seq_count  <= err_seq_count + 16'd1;
            if (keep_err || len_err || seq_err)   error_flag     <= 1'b1;
        end
    end

    // Terminal-count cycle folds in its own beat/packet before the accumulators restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc       <= '0;
            int_pkts  <= '0;
            int_bytes <= '0;
            log_valid <= 1'b0;
            log_pkts  <= '0;
            log_bytes <= '0;
        end else begin
            log_valid <= 1'b0;
            if (cyc == CYCW'(LOG_INTERVAL - 1)) begin
                cyc       <= '0;
                log_valid <= 1'b1;
                log_pkts  <= pkts_sum;
                log_bytes <= bytes_sum;
                int_pkts  <= '0;
                int_bytes <= '0;
            end else begin
                cyc       <= cyc + CYCW'(1);
                int_pkts  <= pkts_sum;
                int_bytes <= bytes_sum;
            end
        end
    end
endmodule

// File: tb/tb_axis_pkt_checker.sv
// Directed, table-driven bench for axis_pkt_checker (default build, LOG_INTERVAL=64).
module tb_axis_pkt_checker;
    localparam int DW     = 512;
    localparam int KW     = DW / 8;
    localparam int LOG_IV = 64;
    localparam logic [63:0] ALL1 = '1;
    localparam logic [63:0] K56  = 64'h00FF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tvalid, tready, tlast;
    logic [31:0]   pkt_count, log_pkts;
    logic [47:0]   byte_count, log_bytes;
    logic [15:0]   err_keep_count, err_len_count, err_seq_count;
    logic          error_flag, log_valid;

    int tests_run    = 0;
    int tests_failed = 0;
    int strobes;
    int last_cyc;

    typedef struct {
        logic [8:0]  seq;
        logic [7:0]  flow;
        logic [63:0] keep;
        logic        last;
        int          exp_pkts;
        int          exp_bytes;
        int          exp_keep;
        int          exp_seq;
        logic        exp_flag;
    } vec_t;

    vec_t vecs [15];

    axis_pkt_checker #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MIN_BEATS(1), .MAX_BEATS(32),
                       .FLOW_IDX_W(4), .LOG_INTERVAL(LOG_IV)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready), .s_axis_tlast(tlast),
        .pkt_count(pkt_count), .byte_count(byte_count),
        .err_keep_count(err_keep_count), .err_len_count(err_len_count),
        .err_seq_count(err_seq_count), .error_flag(error_flag),
        .log_valid(log_valid), .log_pkts(log_pkts), .log_bytes(log_bytes)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [8:0] seq, input logic [7:0] flow,
                                 input logic [63:0] keep, input logic last);
        @(negedge clk);
        tdata             = '0;
        tdata[8:0]        = seq;
        tdata[35*8 +: 8]  = flow;
        tkeep             = keep;
        tvalid            = 1'b1;
        tlast             = last;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            tvalid = 1'b0;
            tlast  = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendPacket(input logic [8:0] seq, input logic [7:0] flow, input int nbeats);
        for (int b = 0; b < nbeats; b++) applyStimulus(seq, flow, ALL1, b == nbeats - 1);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst    = 1'b1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pkts"}, 64'(pkt_count), 0);
        checkOutput({tag, "_bytes"}, 64'(byte_count), 0);
        checkOutput({tag, "_keep"}, 64'(err_keep_count), 0);
        checkOutput({tag, "_len"}, 64'(err_len_count), 0);
        checkOutput({tag, "_seq"}, 64'(err_seq_count), 0);
        checkOutput({tag, "_flag"}, 64'(error_flag), 0);
        checkOutput({tag, "_log_valid"}, 64'(log_valid), 0);
        checkOutput({tag, "_log_pkts"}, 64'(log_pkts), 0);
        checkOutput({tag, "_log_bytes"}, 64'(log_bytes), 0);
    endtask

    initial begin
        rst    = 1'b1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
        tkeep  = '0;

        vecs[0]  = '{9'd10,  8'd44, ALL1,   1'b1, 1,  64,  0, 0, 1'b0};
        vecs[1]  = '{9'd12,  8'd44, ALL1,   1'b1, 2,  128, 0, 0, 1'b0};
        vecs[2]  = '{9'd12,  8'd44, ALL1,   1'b1, 3,  192, 0, 1, 1'b1};
        vecs[3]  = '{9'd5,   8'd44, ALL1,   1'b1, 4,  256, 0, 2, 1'b1};
        vecs[4]  = '{9'd511, 8'd33, ALL1,   1'b1, 5,  320, 0, 2, 1'b1};
        vecs[5]  = '{9'd0,   8'd33, ALL1,   1'b1, 6,  384, 0, 2, 1'b1};
        vecs[6]  = '{9'd20,  8'd33, ALL1,   1'b0, 6,  448, 0, 2, 1'b1};
        vecs[7]  = '{9'd20,  8'd33, K56,    1'b0, 6,  504, 1, 2, 1'b1};
        vecs[8]  = '{9'd20,  8'd33, 64'h0F, 1'b1, 7,  508, 1, 2, 1'b1};
        vecs[9]  = '{9'd21,  8'd33, 64'hF0, 1'b1, 8,  512, 2, 2, 1'b1};
        vecs[10] = '{9'd22,  8'd33, 64'h0,  1'b1, 9,  512, 3, 2, 1'b1};
        vecs[11] = '{9'd300, 8'd50, ALL1,   1'b1, 10, 576, 3, 2, 1'b1};
        vecs[12] = '{9'd301, 8'd66, ALL1,   1'b1, 11, 640, 3, 2, 1'b1};
        vecs[13] = '{9'd45,  8'd82, ALL1,   1'b1, 12, 704, 3, 3, 1'b1};
        vecs[14] = '{9'd300, 8'd50, ALL1,   1'b1, 13, 768, 3, 3, 1'b1};

        doReset();
        checkAllZero("reset");
        checkOutput("reset_tready", 64'(tready), 1);

        // 100 clean 4-beat packets, flows 33/44 interleaved, global seq 1..100
        for (int p = 1; p <= 100; p++) sendPacket(9'(p), (p % 2 == 1) ? 8'd33 : 8'd44, 4);
        idleCycles(1);
        checkOutput("clean_pkts", 64'(pkt_count), 100);
        checkOutput("clean_bytes", 64'(byte_count), 25600);
        checkOutput("clean_keep", 64'(err_keep_count), 0);
        checkOutput("clean_len", 64'(err_len_count), 0);
        checkOutput("clean_seq", 64'(err_seq_count), 0);
        checkOutput("clean_flag", 64'(error_flag), 0);

        doReset();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].seq, vecs[i].flow, vecs[i].keep, vecs[i].last);
            checkOutput($sformatf("vec%0d_pkts", i), 64'(pkt_count), 64'(vecs[i].exp_pkts));
            checkOutput($sformatf("vec%0d_bytes", i), 64'(byte_count), 64'(vecs[i].exp_bytes));
            checkOutput($sformatf("vec%0d_keep", i), 64'(err_keep_count), 64'(vecs[i].exp_keep));
            checkOutput($sformatf("vec%0d_seq", i), 64'(err_seq_count), 64'(vecs[i].exp_seq));
            checkOutput($sformatf("vec%0d_len", i), 64'(err_len_count), 0);
            checkOutput($sformatf("vec%0d_flag", i), 64'(error_flag), 64'(vecs[i].exp_flag));
        end
        idleCycles(1);

        // 40-beat packet: length error raised on beat 33, then a clean follow-up packet
        doReset();
        for (int b = 0; b < 40; b++) begin
            applyStimulus(9'd1, 8'd33, ALL1, b == 39);
            if (b == 31) checkOutput("len_at_beat32", 64'(err_len_count), 0);
            if (b == 32) checkOutput("len_at_beat33", 64'(err_len_count), 1);
        end
        checkOutput("over_len", 64'(err_len_count), 1);
        checkOutput("over_pkts", 64'(pkt_count), 1);
        checkOutput("over_bytes", 64'(byte_count), 2560);
        checkOutput("over_flag", 64'(error_flag), 1);
        sendPacket(9'd2, 8'd33, 4);
        checkOutput("post_over_len", 64'(err_len_count), 1);
        checkOutput("post_over_keep", 64'(err_keep_count), 0);
        checkOutput("post_over_seq", 64'(err_seq_count), 0);
        checkOutput("post_over_pkts", 64'(pkt_count), 2);
        checkOutput("post_over_bytes", 64'(byte_count), 2816);

        // Reset after beat 2 of a 4-beat packet; the tail becomes a fresh 2-beat packet
        applyStimulus(9'd3, 8'd33, ALL1, 1'b0);
        applyStimulus(9'd3, 8'd33, ALL1, 1'b0);
        doReset();
        checkAllZero("midrst");
        applyStimulus(9'd3, 8'd33, ALL1, 1'b0);
        applyStimulus(9'd3, 8'd33, ALL1, 1'b1);
        checkOutput("tail_pkts", 64'(pkt_count), 1);
        checkOutput("tail_bytes", 64'(byte_count), 128);
        checkOutput("tail_len", 64'(err_len_count), 0);
        checkOutput("tail_keep", 64'(err_keep_count), 0);
        checkOutput("tail_seq", 64'(err_seq_count), 0);

        // One 4-beat packet per 8 cycles; skip the first partial window
        doReset();
        strobes  = 0;
        last_cyc = 0;
        fork
            begin
                for (int p = 0; p < 30; p++) begin
                    sendPacket(9'(p), 8'd33, 4);
                    idleCycles(4);
                end
            end
            begin
                for (int c = 0; c < 400 && strobes < 3; c++) begin
                    @(posedge clk);
                    #2;
                    if (log_valid) begin
                        strobes++;
                        if (strobes >= 2) begin
                            checkOutput($sformatf("log%0d_pkts", strobes), 64'(log_pkts), 8);
                            checkOutput($sformatf("log%0d_bytes", strobes), 64'(log_bytes), 2048);
                            checkOutput($sformatf("log%0d_gap", strobes), 64'(c - last_cyc), 64'(LOG_IV));
                        end
                        last_cyc = c;
                    end
                end
                checkOutput("log_strobe_count", 64'(strobes), 3);
            end
        join

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/axis_pkt_checker.md
Name: axis_pkt_checker

Overview:
- Synthesizable sink and checker on the panic egress AXI-Stream port (m_rx_axis_*); consumes what panic delivers toward the DMA side.
- Validates framing, tkeep and per-flow sequence ordering on every packet.
- Keeps running packet/byte/error counters and emits a periodic throughput snapshot, replacing ad-hoc bench checking with reusable RTL usable in simulation and on hardware.

Parameters:
- DATA_WIDTH, 512, AXIS data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- MIN_BEATS, 1, minimum legal beats per packet.
- MAX_BEATS, 32, maximum legal beats per packet.
- FLOW_IDX_W, 4, index bits of the per-flow sequence table; 2^FLOW_IDX_W entries.
- LOG_INTERVAL, 4096, cycles per throughput snapshot.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_axis_tdata  in  DATA_WIDTH  stream data
- s_axis_tkeep  in  KEEP_WIDTH  byte enables
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accept
- s_axis_tlast  in  1  last beat of packet
- pkt_count  out  32  good+bad packets completed, wraps
- byte_count  out  48  sum of popcount(tkeep) over all accepted beats, wraps
- err_keep_count  out  16  tkeep violations, saturating
- err_len_count  out  16  length violations, saturating
- err_seq_count  out  16  sequence violations, saturating
- error_flag  out  1  sticky OR of all error events
- log_valid  out  1  one-cycle snapshot strobe
- log_pkts  out  32  packets completed in closed interval
- log_bytes  out  48  bytes in closed interval

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All counters, log outputs and error_flag clear to 0; flow table valid bits clear; FSM to S_HEAD; s_axis_tready = 1 (without macro).
- Beat accepted when s_axis_tvalid && s_axis_tready. All counter outputs update one cycle after the accepting edge (registered, latency 1).
- FSM S_HEAD (awaiting first beat):
  - Capture seq = tdata[8:0] and flow = tdata[35*8 +: 8].
  - Beat count = 1.
  - If tlast, complete the packet in the same cycle and remain in S_HEAD; else go to S_BODY.
- FSM S_BODY:
  - Increment beat count each accepted beat.
  - If beat count would exceed MAX_BEATS: go to S_SKIP and count one length error.
  - tlast returns the FSM to S_HEAD.
- FSM S_SKIP: accept and count bytes, no further checks; tlast returns to S_HEAD. Packet counts once in pkt_count.
- tkeep rule:
  - Non-last beat: tkeep must be all ones.
  - Last beat: tkeep nonzero and contiguous from LSB, i.e. (tkeep & (tkeep+1)) == 0.
  - Each violating beat increments err_keep_count by 1.
- Length rule: at completion, beats < MIN_BEATS counts a length error. Oversize is already counted on S_SKIP entry and is not counted again.
- Sequence rule, per table entry idx = flow[FLOW_IDX_W-1:0], evaluated at packet completion:
  - Entry invalid: store seq, set valid, no error.
  - Entry valid: diff = (seq - last_seq) mod 512. diff == 0 or diff >= 256 is a sequence error; last_seq is still updated to seq.
  - Serial-number compare so 511 -> 0 is legal.
  - Packets that entered S_SKIP do not update the table.
- Simultaneous events within a cycle: the three error counters increment independently. Each saturates at 16'hFFFF. error_flag sets on any error and clears only on rst.
- Snapshot:
  - Cycle counter runs 0..LOG_INTERVAL-1.
  - On the terminal count cycle, the interval pkt/byte accumulators, including any beat/packet completing in that same cycle, are copied to log_pkts/log_bytes. log_valid pulses next cycle; accumulators restart from 0.
- rst mid-packet: FSM to S_HEAD. A partial packet's remaining beats after reset are treated as a new packet head.

Optional Feature:
- Macro PKT_CHECK_BP_EN.
- Defined:
  - s_axis_tready = LFSR-driven: 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on rst) advances every cycle; tready = ~(lfsr[1:0] == 2'b00), giving ~25% backpressure.
  - tready is 0 during rst.
  - No check rule changes.
- Undefined: tready constant 1 outside reset; no LFSR logic.

Test Plan:
- 100 packets, 4 beats each, full tkeep, flows 33/44 interleaved, global seq 1..100 -> pkt_count=100, byte_count=25600, all err counts 0, error_flag 0.
- Non-last beat with tkeep=64'h00FF...FF -> err_keep_count=1, error_flag=1. Last beat tkeep=64'h0F -> no error; last beat tkeep=64'hF0 -> err_keep_count increments.
- 40-beat packet with MAX_BEATS=32 -> err_len_count=1, pkt_count+1, byte_count+2560, FSM back to S_HEAD after tlast. Next 4-beat packet is clean.
- Flow 44 sends seq 10, 12, then 12, then 5 -> err_seq_count=2; flow 33 seq 511 then 0 -> no error.
- LOG_INTERVAL=64, one 4-beat packet per 8 cycles -> log_valid every 64 cycles with log_pkts=8, log_bytes=2048.
- rst asserted after beat 2 of a 4-beat packet -> all outputs 0 the cycle after, and the remaining 2 beats count as 1 packet with no length error (MIN_BEATS=1).
